spi_master_cfg: RTL and testbench
=================================

// Module: spi_master_cfg
// PURPOSE
//  Parametrised SPI master: the next-generation transfer engine with runtime CPOL/CPHA mode, programmable SCK divider,
//  configurable word width and bit order, and NUM_CS chip selects. It sits between a register/bus front end (start/done
//  handshake) and the board SPI pins. One transfer (one word, full duplex) per start.
// PARAMETERS
//  DATA_W     8  bits per transfer word (>=2)
//  CLK_DIV    2  clk cycles per SCK half-period (>=1)
//  NUM_CS     1  number of active-low chip-select lines (>=1)
//  MSB_FIRST  1  1: shift MSB first; 0: LSB first
//  CS_W       derived = (NUM_CS>1) ? $clog2(NUM_CS) : 1
// PORTS
//  clk      in   1        system clock, all logic on posedge
//  rst_n    in   1        asynchronous active-low reset
//  start    in   1        request; sampled only when busy=0
//  tx_data  in   DATA_W   word to send, latched on accept
//  cs_sel   in   CS_W     chip select index, latched on accept
//  cpol     in   1        SCK idle level, latched on accept
//  cpha     in   1        0: sample on leading edge; 1: sample on trailing edge
//  busy     out  1        transfer in progress
//  done     out  1        one-cycle pulse, rx_data valid
//  err      out  1        one-cycle pulse, start rejected (cs_sel >= NUM_CS)
//  rx_data  out  DATA_W   received word, held until next done
//  sck      out  1        SPI clock
//  mosi     out  1        SPI data out
//  miso     in   1        SPI data in
//  cs_n     out  NUM_CS   chip selects, active low
// BEHAVIOUR
//  Reset (async, rst_n=0): sck=0, mosi=0, cs_n=all 1, busy=0, done=0, err=0, rx_data=0, state IDLE; aborts any transfer
//   immediately with no done pulse.
//  States: IDLE -> LEAD -> XFER -> TRAIL -> IDLE. Edge 0 = clk edge where start is accepted.
//  IDLE: sck follows cpol input (registered), cs_n all 1. start=1 & cs_sel<NUM_CS: latch tx_data/cs_sel/cpol/cpha,
//   cs_n[cs_sel]<=0, busy<=1, go LEAD. start=1 & cs_sel>=NUM_CS: err pulse at edge 0, stay IDLE, cs_n untouched.
//  SCK edges: edge k (k=1..2*DATA_W) toggles sck at clk edge k*CLK_DIV; odd k = leading, even k = trailing.
//  cpha=0: first bit on mosi at edge 0; miso sampled on leading edges; next bit driven on trailing edges (not after last).
//  cpha=1: bit driven on leading edges; miso sampled on trailing edges.
//  Sampling uses the miso value present at the same clk edge the sck toggle is registered.
//  TRAIL: sck stays at latched cpol for CLK_DIV cycles; at edge (2*DATA_W+1)*CLK_DIV: cs_n all 1, rx_data updated,
//   done=1 for one cycle, busy=0, mosi=0, state IDLE.
//  Latency start-accept -> done: (2*DATA_W+1)*CLK_DIV cycles (34 for defaults). start during the done cycle is accepted
//   at the next edge, guaranteeing >=1 cycle of cs_n high between transfers.
//  start, tx_data, cs_sel, cpol, cpha changes while busy=1 are ignored; in-flight transfer uses latched values.
//  Bit order: MSB_FIRST=1 tx bit DATA_W-1 first and rx fills from MSB; 0 mirrors. Shift registers DATA_W wide, no extension.
//  Counters: half-period counter 0..CLK_DIV-1 wraps; edge counter 0..2*DATA_W, width $clog2(2*DATA_W+1).
// STRUCTURE
//  spi_defs.vh: state encodings (IDLE/LEAD/XFER/TRAIL), mode constants MODE0..MODE3 for benches.
//  Sub-module spi_sck_gen: half-period counter + edge counter, outputs lead_stb/trail_stb/last_edge; the
//  spi_master_cfg top holds FSM, shift registers, cs decode.
// TESTING
//  Mode 0, DATA_W=8, CLK_DIV=2, tx 0xA5, slave model returns 0x3C -> mosi bits 1,0,1,0,0,1,0,1; rx_data=0x3C; done at edge 34.
//  Modes 1/2/3 same data -> sck idles at cpol, sampling edge per cpha, rx_data=0x3C, mosi matches slave-captured 0xA5 each mode.
//  NUM_CS=4, cs_sel=2 then cs_sel=5 -> cs_n=4'b1011 during first; second gives err pulse, cs_n stays 4'b1111, no done.
//  Back-to-back: start held high -> two transfers, cs_n high >=1 cycle between, exactly one done per transfer.
//  rst_n low at edge 10 mid-transfer -> immediately cs_n=all 1, sck=0, busy=0, no done; next start completes normally.
//  MSB_FIRST=0, DATA_W=16, CLK_DIV=3, tx 0x8001 -> mosi LSB first (1,0..0,1); done at edge 99.

Source files
------------

// File: rtl/spi_master_cfg_pkg.sv
// Shared definitions for the configurable SPI master.
//  - spi_state_e : transfer FSM states (IDLE -> LEAD -> XFER -> TRAIL -> IDLE)
//  - MODE0..MODE3: {cpol, cpha} encodings of the four SPI modes, for benches/drivers
package spi_master_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_e;

  // {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK timing for one transfer.
//  clk, rst_n : system clock, async active-low reset
//  en         : high while a transfer is in flight; counters held at 0 otherwise
//  lead_stb   : this clk edge registers a leading SCK toggle (odd edge k)
//  trail_stb  : this clk edge registers a trailing SCK toggle (even edge k)
//  last_trail : qualifier, the pending trailing toggle is the final one (k = 2*DATA_W)
//  last_edge  : end of the trailing CS hold, k = 2*DATA_W+1
// Edge k fires at clk edge k*CLK_DIV counted from the accept edge.
module spi_sck_gen #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic lead_stb,
  output logic trail_stb,
  output logic last_trail,
  output logic last_edge
);
  localparam int HP_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EC_W = $clog2(2 * DATA_W + 1);

  logic [HP_W-1:0] hp_cnt;
  logic [EC_W-1:0] edge_cnt;   // number of strobes already issued
  logic            stb;

  assign stb        = en && (hp_cnt == HP_W'(CLK_DIV - 1));
  assign last_edge  = stb && (edge_cnt == EC_W'(2 * DATA_W));
  assign lead_stb   = stb && !edge_cnt[0] && !last_edge;
  assign trail_stb  = stb && edge_cnt[0];
  assign last_trail = (edge_cnt == EC_W'(2 * DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_cnt   <= '0;
      edge_cnt <= '0;
    end else if (!en) begin
      hp_cnt   <= '0;
      edge_cnt <= '0;
    end else if (stb) begin
      hp_cnt   <= '0;
      edge_cnt <= last_edge ? '0 : edge_cnt + 1'b1;
    end else begin
      hp_cnt   <= hp_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_master_cfg.sv
// SPI master, one full-duplex word per start, runtime CPOL/CPHA.
//  clk, rst_n     : system clock, async active-low reset
//  start          : transfer request, sampled only while idle
//  tx_data/cs_sel/cpol/cpha : transfer setup, latched on accept
//  busy           : transfer in flight
//  done           : 1-cycle pulse, rx_data valid
//  err            : 1-cycle pulse, start rejected because cs_sel >= NUM_CS
//  rx_data        : last received word, held until the next done
//  sck/mosi/miso/cs_n : SPI pins, cs_n active low
module spi_master_cfg
  import spi_master_cfg_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int NUM_CS    = 1,
  parameter int MSB_FIRST = 1,
  parameter int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rx_data,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);
  spi_state_e        state;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic              cpha_q;
  logic              cs_ok;
  logic              lead_stb, trail_stb, last_trail, last_edge;

  // NUM_CS <= 2**CS_W, so one extra bit holds it for the range check.
  assign cs_ok = ({1'b0, cs_sel} < (CS_W + 1)'(NUM_CS));

  spi_sck_gen #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) u_sck (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state != ST_IDLE),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .last_trail(last_trail),
    .last_edge (last_edge)
  );

  function automatic logic out_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
    return (MSB_FIRST != 0) ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= '1;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rx_data <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      cpha_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          sck  <= cpol;  // idle level tracks the input until a transfer latches it
          cs_n <= '1;
          if (start) begin
            if (cs_ok) begin
              cpha_q <= cpha;
              cs_n   <= ~(NUM_CS'(1) << cs_sel);
              busy   <= 1'b1;
              state  <= ST_LEAD;
              if (!cpha) begin
                // cpha=0: first bit must be valid before the first (sampling) edge
                mosi  <= out_bit(tx_data);
                tx_sr <= shift_out(tx_data);
              end else begin
                tx_sr <= tx_data;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_LEAD, ST_XFER: begin
          if (lead_stb) begin
            sck   <= ~sck;
            state <= ST_XFER;
            if (cpha_q) begin
              mosi  <= out_bit(tx_sr);
              tx_sr <= shift_out(tx_sr);
            end else begin
              rx_sr <= shift_in(rx_sr, miso);
            end
          end
          if (trail_stb) begin
            sck <= ~sck;
            if (cpha_q) begin
              rx_sr <= shift_in(rx_sr, miso);
            end else if (!last_trail) begin
              mosi  <= out_bit(tx_sr);
              tx_sr <= shift_out(tx_sr);
            end
            if (last_trail) state <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          if (last_edge) begin
            cs_n    <= '1;
            rx_data <= rx_sr;
            done    <= 1'b1;
            busy    <= 1'b0;
            mosi    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg. Three instances share clk/rst_n:
//  u0: DATA_W=8  CLK_DIV=2 NUM_CS=1 MSB first
//  u1: DATA_W=8  CLK_DIV=2 NUM_CS=5 MSB first (5 so an out-of-range cs_sel is encodable)
//  u2: DATA_W=16 CLK_DIV=3 NUM_CS=1 LSB first
// A mode-aware SPI slave model watches each instance's pins and records what it captured.
module tb_spi_master_cfg;
  import spi_master_cfg_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [2:0]  start = '0, cpol_i = '0, cpha_i = '0, miso_r = '0;
  logic [7:0]  tx0 = '0, tx1 = '0;
  logic [15:0] tx2 = '0;
  logic        cs_sel0 = 1'b0, cs_sel2 = 1'b0;
  logic [2:0]  cs_sel1 = '0;
  wire  [2:0]  busy_w, done_w, err_w, sck_w, mosi_w;
  wire  [7:0]  rx0, rx1;
  wire  [15:0] rx2;
  wire         cs0, cs2;
  wire  [4:0]  cs1;

  spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(1), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .tx_data(tx0), .cs_sel(cs_sel0),
    .cpol(cpol_i[0]), .cpha(cpha_i[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]),
    .rx_data(rx0), .sck(sck_w[0]), .mosi(mosi_w[0]), .miso(miso_r[0]), .cs_n(cs0));

  spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(5), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .tx_data(tx1), .cs_sel(cs_sel1),
    .cpol(cpol_i[1]), .cpha(cpha_i[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]),
    .rx_data(rx1), .sck(sck_w[1]), .mosi(mosi_w[1]), .miso(miso_r[1]), .cs_n(cs1));

  spi_master_cfg #(.DATA_W(16), .CLK_DIV(3), .NUM_CS(1), .MSB_FIRST(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .tx_data(tx2), .cs_sel(cs_sel2),
    .cpol(cpol_i[2]), .cpha(cpha_i[2]), .busy(busy_w[2]), .done(done_w[2]), .err(err_w[2]),
    .rx_data(rx2), .sck(sck_w[2]), .mosi(mosi_w[2]), .miso(miso_r[2]), .cs_n(cs2));

  // ---- per-instance configuration knowledge ----
  function automatic int dw(input int i);   return (i == 2) ? 16 : 8; endfunction
  function automatic int lat(input int i);  return (2 * dw(i) + 1) * ((i == 2) ? 3 : 2); endfunction
  function automatic logic [15:0] mask(input int i); return (i == 2) ? 16'hffff : 16'h00ff; endfunction
  // bit index carrying the n-th bit on the wire
  function automatic int bpos(input int i, input int n); return (i == 2) ? n : dw(i) - 1 - n; endfunction
  function automatic logic [4:0] idle_cs(input int i); return (i == 1) ? 5'h1f : 5'h01; endfunction

  function automatic logic [15:0] rx_of(input int i);
    case (i)
      0: return {8'h00, rx0};
      1: return {8'h00, rx1};
      default: return rx2;
    endcase
  endfunction

  function automatic logic [4:0] cs_of(input int i);
    case (i)
      0: return {4'b0000, cs0};
      1: return cs1;
      default: return {4'b0000, cs2};
    endcase
  endfunction

  task automatic set_in(input int i, input logic [15:0] d, input logic [2:0] cs,
                        input logic pol, input logic pha, input logic st);
    cpol_i[i] = pol; cpha_i[i] = pha; start[i] = st;
    case (i)
      0: begin tx0 = d[7:0]; cs_sel0 = cs[0]; end
      1: begin tx1 = d[7:0]; cs_sel1 = cs; end
      default: begin tx2 = d; cs_sel2 = cs[0]; end
    endcase
  endtask

  // ---- SPI slave model ----
  logic [15:0] s_word[3];
  logic [15:0] s_rx[3];
  logic [15:0] s_got[3];
  int          s_got_edges[3];
  int          s_ns[3], s_nd[3], s_edges[3];
  logic        s_act[3] = '{1'b0, 1'b0, 1'b0};
  logic        s_prev[3];
  logic        m_cpol[3] = '{1'b0, 1'b0, 1'b0};
  logic        m_cpha[3] = '{1'b0, 1'b0, 1'b0};

  always @(negedge clk) begin
    logic lead;
    for (int i = 0; i < 3; i++) begin
      if (cs_of(i) === idle_cs(i)) begin
        if (s_act[i]) begin s_got[i] = s_rx[i]; s_got_edges[i] = s_edges[i]; end
        s_act[i] = 1'b0;
      end else if (!s_act[i]) begin
        s_act[i] = 1'b1; s_rx[i] = '0; s_ns[i] = 0; s_nd[i] = 0; s_edges[i] = 0;
        s_prev[i] = sck_w[i];
        if (!m_cpha[i]) begin miso_r[i] = s_word[i][bpos(i, 0)]; s_nd[i] = 1; end
      end else if (sck_w[i] !== s_prev[i]) begin
        s_edges[i]++;
        s_prev[i] = sck_w[i];
        lead = (sck_w[i] != m_cpol[i]);
        if (lead != m_cpha[i]) begin
          if (s_ns[i] < dw(i)) s_rx[i][bpos(i, s_ns[i])] = mosi_w[i];
          s_ns[i]++;
        end else if (s_nd[i] < dw(i)) begin
          miso_r[i] = s_word[i][bpos(i, s_nd[i])];
          s_nd[i]++;
        end
      end
    end
  end

  // ---- one complete transfer with full checking ----
  task automatic xfer(input int i, input logic [15:0] d, input logic [15:0] sw, input logic pol,
                      input logic pha, input logic [2:0] cs, input logic [4:0] exp_cs);
    int dn, nd;
    dn = -1; nd = 0;
    @(negedge clk);
    set_in(i, d, cs, pol, pha, 1'b0);
    m_cpol[i] = pol; m_cpha[i] = pha; s_word[i] = sw & mask(i);
    @(negedge clk); #1;
    checks++; if (sck_w[i] !== pol) begin failures++; $display("FAIL idle_sck[%0d]: got %b want %b", i, sck_w[i], pol); end
    start[i] = 1'b1;
    @(posedge clk); #1;
    // setup changes while busy must not disturb the transfer
    set_in(i, 16'($urandom), 3'($urandom_range(0, 7)), ~pol, ~pha, 1'b0);
    @(negedge clk); #1;
    checks++; if (cs_of(i) !== exp_cs) begin failures++; $display("FAIL cs_n_active[%0d]: got %b want %b", i, cs_of(i), exp_cs); end
    checks++; if (busy_w[i] !== 1'b1) begin failures++; $display("FAIL busy_set[%0d]: got %b want 1", i, busy_w[i]); end
    for (int n = 1; n <= lat(i) + 3; n++) begin
      @(posedge clk); @(negedge clk); #1;
      if (done_w[i] === 1'b1) begin
        nd++;
        if (dn < 0) begin
          dn = n;
          checks++; if (rx_of(i) !== (sw & mask(i))) begin failures++; $display("FAIL rx_data[%0d]: got %h want %h", i, rx_of(i), sw & mask(i)); end
          checks++; if (s_got[i] !== (d & mask(i))) begin failures++; $display("FAIL mosi_word[%0d]: got %h want %h", i, s_got[i], d & mask(i)); end
          checks++; if (s_got_edges[i] !== 2 * dw(i)) begin failures++; $display("FAIL sck_edges[%0d]: got %0d want %0d", i, s_got_edges[i], 2 * dw(i)); end
          checks++; if (sck_w[i] !== pol) begin failures++; $display("FAIL end_sck[%0d]: got %b want %b", i, sck_w[i], pol); end
          checks++; if (cs_of(i) !== idle_cs(i)) begin failures++; $display("FAIL cs_n_release[%0d]: got %b want %b", i, cs_of(i), idle_cs(i)); end
          checks++; if (busy_w[i] !== 1'b0 || mosi_w[i] !== 1'b0) begin failures++; $display("FAIL end_busy_mosi[%0d]: got %b%b want 00", i, busy_w[i], mosi_w[i]); end
        end
      end
    end
    checks++; if (dn !== lat(i)) begin failures++; $display("FAIL done_latency[%0d]: got %0d want %0d", i, dn, lat(i)); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL done_count[%0d]: got %0d want 1", i, nd); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (sck_w[i] !== 1'b0 || mosi_w[i] !== 1'b0) begin failures++; $display("FAIL rst_pins[%0d]: got %b%b want 00", i, sck_w[i], mosi_w[i]); end
      checks++; if (cs_of(i) !== idle_cs(i)) begin failures++; $display("FAIL rst_cs_n[%0d]: got %b want %b", i, cs_of(i), idle_cs(i)); end
      checks++; if ({busy_w[i], done_w[i], err_w[i]} !== 3'b000) begin failures++; $display("FAIL rst_flags[%0d]: got %b want 000", i, {busy_w[i], done_w[i], err_w[i]}); end
      checks++; if (rx_of(i) !== 16'h0) begin failures++; $display("FAIL rst_rx[%0d]: got %h want 0", i, rx_of(i)); end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_modes;
    logic [1:0] modes[4];
    modes = '{MODE0, MODE1, MODE2, MODE3};
    for (int m = 0; m < 4; m++) xfer(0, 16'h00A5, 16'h003C, modes[m][1], modes[m][0], 3'd0, 5'b00000);
  endtask

  task automatic test_random;
    logic [2:0] cs;
    for (int k = 0; k < 6; k++)
      xfer(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 3'd0, 5'b00000);
    for (int k = 0; k < 3; k++) begin
      cs = 3'($urandom_range(0, 4));
      xfer(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), cs, 5'h1f & ~(5'd1 << cs));
    end
  endtask

  task automatic err_case(input int i, input logic [2:0] cs);
    int bad;
    bad = 0;
    @(negedge clk); set_in(i, 16'h5A5A, cs, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checks++; if (err_w[i] !== 1'b1) begin failures++; $display("FAIL err_pulse[%0d]: got %b want 1", i, err_w[i]); end
    checks++; if (busy_w[i] !== 1'b0 || cs_of(i) !== idle_cs(i)) begin failures++; $display("FAIL err_idle[%0d]: got busy=%b cs_n=%b want busy=0 cs_n=%b", i, busy_w[i], cs_of(i), idle_cs(i)); end
    start[i] = 1'b0;
    @(posedge clk); #1;
    checks++; if (err_w[i] !== 1'b0) begin failures++; $display("FAIL err_one_cycle[%0d]: got %b want 0", i, err_w[i]); end
    for (int n = 0; n < lat(i) + 2; n++) begin
      @(posedge clk); #1;
      if (done_w[i] !== 1'b0 || cs_of(i) !== idle_cs(i)) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL err_no_xfer[%0d]: got %0d active cycles want 0", i, bad); end
  endtask

  task automatic test_cs_err;
    xfer(1, 16'h00A5, 16'h003C, 1'b0, 1'b0, 3'd2, 5'b11011);
    err_case(1, 3'd5);
    err_case(0, 3'd1);
  endtask

  task automatic test_back_to_back;
    logic [15:0] d1, d2, sw, ed;
    int dn[2];
    int nd, gap;
    d1 = 16'($urandom) & 16'h00ff; d2 = 16'($urandom) & 16'h00ff; sw = 16'($urandom) & 16'h00ff;
    dn[0] = -1; dn[1] = -1; nd = 0; gap = 0;
    @(negedge clk);
    set_in(0, d1, 3'd0, 1'b0, 1'b0, 1'b1);
    m_cpol[0] = 1'b0; m_cpha[0] = 1'b0; s_word[0] = sw;
    @(posedge clk); #1;
    tx0 = d2[7:0];
    for (int n = 1; n <= 2 * lat(0) + 4; n++) begin
      @(posedge clk); @(negedge clk); #1;
      if (done_w[0] === 1'b1) begin
        ed = (nd == 0) ? d1 : d2;
        if (nd < 2) dn[nd] = n;
        checks++; if (rx_of(0) !== sw) begin failures++; $display("FAIL b2b_rx[%0d]: got %h want %h", nd, rx_of(0), sw); end
        checks++; if (s_got[0] !== ed) begin failures++; $display("FAIL b2b_mosi[%0d]: got %h want %h", nd, s_got[0], ed); end
        nd++;
        if (nd >= 2) start[0] = 1'b0;
      end
      if (nd == 1 && cs0 === 1'b1) gap++;
    end
    start[0] = 1'b0;
    checks++; if (nd !== 2) begin failures++; $display("FAIL b2b_done_count: got %0d want 2", nd); end
    checks++; if (dn[0] !== lat(0) || dn[1] !== 2 * lat(0) + 1) begin failures++; $display("FAIL b2b_done_time: got %0d,%0d want %0d,%0d", dn[0], dn[1], lat(0), 2 * lat(0) + 1); end
    checks++; if (gap < 1) begin failures++; $display("FAIL b2b_cs_gap: got %0d cycles want >=1", gap); end
  endtask

  task automatic test_abort;
    int nd;
    nd = 0;
    @(negedge clk);
    set_in(0, 16'h00C3, 3'd0, 1'b0, 1'b0, 1'b1);
    m_cpol[0] = 1'b0; m_cpha[0] = 1'b0; s_word[0] = 16'h0055;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (cs0 !== 1'b1 || sck_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin failures++; $display("FAIL abort_state: got cs_n=%b sck=%b busy=%b want 1 0 0", cs0, sck_w[0], busy_w[0]); end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0) nd++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0) nd++;
    end
    checks++; if (nd !== 0) begin failures++; $display("FAIL abort_no_done: got %0d done cycles want 0", nd); end
    xfer(0, 16'h005A, 16'h00E1, 1'b0, 1'b0, 3'd0, 5'b00000);
  endtask

  task automatic test_lsb_wide;
    xfer(2, 16'h8001, 16'h3C5A, 1'b0, 1'b0, 3'd0, 5'b00000);
    for (int k = 0; k < 3; k++)
      xfer(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 3'd0, 5'b00000);
  endtask

  initial begin
    test_reset;
    test_modes;
    test_random;
    test_cs_err;
    test_back_to_back;
    test_abort;
    test_lsb_wide;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
